// File: rtl/rhythm_pkg.sv
// Shared sizes, score weights and FSM encoding for the note field.
// Imported by the chart bus interface and the note_field_gen slice.
package rhythm_pkg;

  localparam int LANES   = 4;
  localparam int ROWS    = 16;
  localparam int SCORE_W = 16;
  localparam int COMBO_W = 8;
  localparam int FIELD_W = LANES * ROWS;

  localparam int PERFECT_PTS = 2;
  localparam int GOOD_PTS    = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int lane_cnt(
    input logic [LANES-1:0] v
  );
    int n;
    n = 0;
    for (int i = 0; i < LANES; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/note_field_gen_if.sv
// Chart ROM bus: registered address out, lane bitmap back one cycle later.
// master = note_field_gen, slave = chart ROM.
interface note_field_gen_if;

  logic [7:0]                  chart_addr;
  logic [rhythm_pkg::LANES-1:0] chart_data;

  modport master (
    output chart_addr,
    input  chart_data
  );

  modport slave (
    input  chart_addr,
    output chart_data
  );

endinterface

// File: rtl/hit_flash_timer.sv
// One lane's hit flash: lit for exactly HIT_HOLD cycles after a hit.
// A new hit reloads the counter.
module hit_flash_timer #(
  parameter logic [23:0] HIT_HOLD = 24'd5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  output logic led
);

  logic [23:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (hit) begin
      cnt <= HIT_HOLD;
    end else if (cnt != '0) begin
      cnt <= cnt - 24'd1;
    end
  end

  assign led = (cnt != '0);

endmodule

// File: rtl/note_field_gen.sv
// Scrolling 4-lane note field with hit judgement, score and combo.
// Define NOTE_FIELD_MISS_PENALTY_EN to also take 1 point per missed note.
module note_field_gen
  import rhythm_pkg::*;
#(
  parameter logic [7:0]  CHART_LEN = 8'd128,
  parameter logic [23:0] HIT_HOLD  = 24'd5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                tick,
  input  logic [LANES-1:0]    keys,
  note_field_gen_if.master    rom,
  output logic [FIELD_W-1:0]  note_field,
  output logic [LANES-1:0]    hit_leds,
  output logic [SCORE_W-1:0]  score,
  output logic [COMBO_W-1:0]  combo,
  output logic                busy,
  output logic                done
);

  localparam int R15 = FIELD_W - 1;
  localparam int R14 = FIELD_W - LANES - 1;
  localparam int SMAX = (1 << SCORE_W) - 1;
  localparam int CMAX = (1 << COMBO_W) - 1;

  state_t             state;
  logic [LANES-1:0]   keys_q;
  logic [3:0]         drain_cnt;

  logic               judge_en;
  logic               shift;
  logic [LANES-1:0]   row15;
  logic [LANES-1:0]   row14;
  logic [LANES-1:0]   edge_k;
  logic [LANES-1:0]   hit_p;
  logic [LANES-1:0]   hit_g;
  logic [LANES-1:0]   miss;
  logic [LANES-1:0]   fill;
  logic [FIELD_W-1:0] judged;
  logic [FIELD_W-1:0] field_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [COMBO_W-1:0] combo_nxt;
  int                 sc;
  int                 cb;

  // Judge on the pre-shift field; a bit hit this cycle is never a miss.
  always_comb begin
    judge_en = (state == S_RUN) || (state == S_DRAIN);
    shift    = judge_en && tick;
    row15    = note_field[R15 -: LANES];
    row14    = note_field[R14 -: LANES];
    edge_k   = judge_en ? (keys & ~keys_q) : '0;
    hit_p    = edge_k & row15;
    hit_g    = edge_k & ~row15 & row14;

    judged              = note_field;
    judged[R15 -: LANES] = row15 & ~hit_p;
    judged[R14 -: LANES] = row14 & ~hit_g;

    miss = shift ? (row15 & ~hit_p) : '0;
    fill = (state == S_RUN) ? rom.chart_data : '0;

    if (shift) begin
      field_nxt = {judged[R14:0], fill};
    end else begin
      field_nxt = judged;
    end

    sc = int'(score)
       + PERFECT_PTS * lane_cnt(hit_p)
       + GOOD_PTS * lane_cnt(hit_g);
`ifdef NOTE_FIELD_MISS_PENALTY_EN
    sc = sc - lane_cnt(miss);
    if (sc < 0) sc = 0;
`endif
    score_nxt = (sc > SMAX) ? '1 : SCORE_W'(sc);

    // Misses reset first, then this cycle's hits are added.
    cb = (|miss) ? 0 : int'(combo);
    cb = cb + lane_cnt(hit_p | hit_g);
    combo_nxt = (cb > CMAX) ? '1 : COMBO_W'(cb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      note_field     <= '0;
      score          <= '0;
      combo          <= '0;
      rom.chart_addr <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      keys_q         <= '0;
      drain_cnt      <= '0;
    end else begin
      keys_q <= keys;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_PRIME;
            note_field     <= '0;
            score          <= '0;
            combo          <= '0;
            drain_cnt      <= '0;
            rom.chart_addr <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
          end
        end
        S_PRIME: begin
          state <= S_RUN;
        end
        S_RUN, S_DRAIN: begin
          note_field <= field_nxt;
          score      <= score_nxt;
          combo      <= combo_nxt;
          if (shift) begin
            if (state == S_RUN) begin
              rom.chart_addr <= rom.chart_addr + 8'd1;
              if (rom.chart_addr == CHART_LEN - 8'd1) begin
                state <= S_DRAIN;
              end
            end else begin
              drain_cnt <= drain_cnt + 4'd1;
              if (drain_cnt == 4'd15) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_flash
    hit_flash_timer #(
      .HIT_HOLD(HIT_HOLD)
    ) u_flash (
      .clk(clk),
      .rst(rst),
      .hit(hit_p[i] | hit_g[i]),
      .led(hit_leds[i])
    );
  end

endmodule

// File: doc/note_field_gen.md
NOTE_FIELD_GEN -- requirements
Module: note_field_gen

Interface
REQ-001 SHALL have parameter CHART_LEN, default 8'd128, meaning the number of chart rows fetched before drain.
REQ-002 SHALL have parameter HIT_HOLD, default 24'd5_000_000, meaning hit-flash duration in clk cycles.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, meaning a 1-cycle pulse that begins a song.
REQ-006 SHALL have port tick, input, 1, meaning a 1-cycle scroll strobe; consecutive pulses are at least 2 cycles apart.
REQ-007 SHALL have port keys, input, 4, meaning debounced lane buttons (level, 1 = pressed).
REQ-008 SHALL have port chart_addr, output, 8, meaning the registered chart ROM address.
REQ-009 SHALL have port chart_data, input, 4, meaning the lane bitmap returned by the ROM 1 cycle after chart_addr changes.
REQ-010 SHALL have port note_field, output, 64, meaning row r at bits [4r+3:4r], with row 0 at top and row 15 at the judge line.
REQ-011 SHALL have port hit_leds, output, 4, meaning per-lane hit flash.
REQ-012 SHALL have port score, output, 16, meaning the accumulated score.
REQ-013 SHALL have port combo, output, 8, meaning the current consecutive-hit count.
REQ-014 SHALL have port busy, output, 1, meaning the block is in PRIME, RUN or DRAIN.
REQ-015 SHALL have port done, output, 1, meaning the block is in DONE.

Function
REQ-016 SHALL implement FSM IDLE, PRIME, RUN, DRAIN, DONE with these transitions:
- IDLE to PRIME on start.
- PRIME to RUN after exactly 1 cycle.
- RUN to DRAIN on the tick that loads row CHART_LEN-1.
- DRAIN to DONE on the 16th drain tick.
- DONE to PRIME on start.
REQ-017 On entry to PRIME, the block SHALL clear note_field, score, combo and the drain counter and set chart_addr=0; tick in PRIME is ignored.
REQ-018 On tick in RUN, the block SHALL:
- shift the field down one row (row r+1 <= row r);
- load row 0 with chart_data;
- increment chart_addr;
- make the updated note_field visible the cycle after the tick.
REQ-019 On tick in DRAIN, the block SHALL shift with row 0 loaded with 4'b0 and chart_addr held.
REQ-020 The block SHALL detect a key press as a rising edge of keys[i] against the previous cycle's registered value; edges are judged only in RUN or DRAIN.
REQ-021 Judgement per lane i, priority order:
- row15[i]=1: PERFECT; clear the bit, score +2, combo +1.
- else row14[i]=1: GOOD; clear the bit, score +1, combo +1.
- else: no effect.
REQ-022 Several lanes judged in the same cycle SHALL sum their score and combo increments.
REQ-023 A row15 bit still set when a tick shifts it out SHALL count as a MISS: combo <= 0; several misses on one tick count as one combo reset.
REQ-024 For a key edge and a tick in the same cycle, the block SHALL judge on the pre-shift field first. A note hit that cycle is not counted as a miss; the shifted field excludes cleared bits.
REQ-025 A hit and a miss in the same cycle SHALL result in combo = hit increment only (reset then add).
REQ-026 score SHALL saturate at 16'hFFFF and combo SHALL saturate at 8'hFF.
REQ-027 hit_leds[i] SHALL go 1 the cycle after a PERFECT or GOOD in lane i and stay 1 for exactly HIT_HOLD cycles; a re-hit restarts the count.
REQ-028 start in PRIME, RUN or DRAIN SHALL be ignored.

Reset
REQ-029 While rst=1, state = IDLE, and note_field, hit_leds, score, combo, chart_addr, busy and done = 0, and all flash counters = 0; this applies mid-song too.
REQ-030 The key edge register SHALL reset to 4'b0, so keys held high through reset produce an edge on the first cycle after reset; that edge is discarded because the state is IDLE.

Configuration
REQ-031 Macro NOTE_FIELD_MISS_PENALTY_EN: when defined, each missed note also decrements score by 1, saturating at 0, summed per lane on the same tick.
- When undefined, a miss only resets combo.

Structure
REQ-032 Package rhythm_pkg SHALL hold LANES=4, ROWS=16, SCORE_W=16, COMBO_W=8, the FSM state enum and the PERFECT/GOOD score constants.
REQ-033 Sub-module hit_flash_timer (one lane's HIT_HOLD counter) SHALL be instantiated LANES times.

Verification
REQ-034 Reset check: assert rst for 3 cycles during RUN -> all outputs 0, state IDLE, ticks ignored.
REQ-035 PERFECT hit: CHART_LEN=4, chart={1,0,0,0}, start, 16 ticks -> note_field[63:60]=4'b0001; keys[0] rising -> score=2, combo=1, hit_leds[0]=1 for HIT_HOLD=8 cycles.
REQ-036 GOOD hit: same chart after 15 ticks, keys[0] rising -> score=1, combo=1, row14 bit cleared.
REQ-037 Miss: 17 ticks with no key -> combo=0; with NOTE_FIELD_MISS_PENALTY_EN, a prior score of 1 becomes 0, and a prior score of 0 stays 0.
REQ-038 Same-cycle event: key edge on the same cycle as the 17th tick -> PERFECT counted, combo=1, no miss.
REQ-039 Drain and restart: CHART_LEN=4 -> done=1 after exactly 4+16 ticks; start -> score=0, busy=1, chart_addr=0.
